// File: rtl/fetch_stage.sv
// IF stage: owns the fetch PC, issues one outstanding imem request at a time,
// and drives the IF/ID pipeline register (stall/flush/redirect aware).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ready_in,
  input  logic [31:0] imem_rdata_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  output logic        valid_out
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP      = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  localparam logic [1:0] S_FETCH   = 2'd0;
  localparam logic [1:0] S_HOLD    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            valid_q, valid_d;

  logic            done;
  logic            capture;
  logic [XLEN-1:0] cap_instr;
  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] pc_inc;

  // Next-state: fetch FSM plus IF/ID register update
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_d     = buf_q;
    tgt_d     = tgt_q;
    instr_d   = instr_q;
    pc_out_d  = pc_out_q;
    pc4_d     = pc4_q;
    valid_d   = valid_q;
    capture   = 1'b0;
    cap_instr = buf_q;

    done         = req_q & imem_ready_in;
    redirect_tgt = redirect_pc_in & ALIGN_MASK;
    pc_inc       = pc_q + PC_STEP;

    case (state_q)
      S_FETCH: begin
        // req_q low only in the first cycle out of reset: nothing in flight
        if (!req_q) begin
          if (redirect_in) pc_d = redirect_tgt;
        end else if (done) begin
          if (redirect_in) begin
            pc_d = redirect_tgt;
          end else if (!stall_in) begin
            capture   = 1'b1;
            cap_instr = imem_rdata_in;
            pc_d      = pc_inc;
          end else begin
            buf_d   = imem_rdata_in;
            state_d = S_HOLD;
          end
        end else if (redirect_in) begin
          tgt_d   = redirect_tgt;
          state_d = S_DISCARD;
        end
      end
      S_HOLD: begin
        if (redirect_in) begin
          pc_d    = redirect_tgt;
          buf_d   = '0;
          state_d = S_FETCH;
        end else if (!stall_in) begin
          capture   = 1'b1;
          cap_instr = buf_q;
          pc_d      = pc_inc;
          buf_d     = '0;
          state_d   = S_FETCH;
        end
      end
      S_DISCARD: begin
        // Address held at pc_q until the stale response drains
        if (done) begin
          pc_d    = redirect_in ? redirect_tgt : tgt_q;
          tgt_d   = '0;
          state_d = S_FETCH;
        end else if (redirect_in) begin
          tgt_d = redirect_tgt;
        end
      end
      default: state_d = S_FETCH;
    endcase

    req_d = (state_d != S_HOLD);

    if (flush_in) begin
      valid_d = 1'b0;
      instr_d = NOP;
    end else if (stall_in) begin
      valid_d = valid_q;
    end else if (capture) begin
      instr_d  = cap_instr;
      pc_out_d = pc_q;
      pc4_d    = pc_inc;
      valid_d  = 1'b1;
    end else begin
      valid_d = 1'b0;
      instr_d = NOP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      buf_q    <= '0;
      tgt_q    <= '0;
      instr_q  <= NOP;
      pc_out_q <= '0;
      pc4_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      buf_q    <= buf_d;
      tgt_q    <= tgt_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
    end
  end

  assign imem_req_out  = req_q;
  assign imem_addr_out = pc_q;
  assign instr_out     = instr_q;
  assign pc_out        = pc_out_q;
  assign pc_plus4_out  = pc4_q;
  assign valid_out     = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed test-plan scenarios with literal checks, then
// randomized stall/flush/redirect/latency traffic checked against a reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall_in, flush_in, redirect_in;
  logic [31:0] redirect_pc_in;
  logic        imem_req_out, imem_ready_in;
  logic [31:0] imem_addr_out, imem_rdata_in;
  logic [31:0] instr_out, pc_out, pc_plus4_out;
  logic        valid_out;
  logic        rdy_en;

  logic        w_req, w_ready, w_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pc4;
  logic        tie0;
  logic [31:0] tie0_32;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'hFFF3_0293;
      32'h0000_0004: mem_word = 32'hFE20_AE23;
      32'h0000_0008: mem_word = 32'hFE00_8CE3;
      default:       mem_word = {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  assign imem_ready_in = rdy_en & imem_req_out;
  assign imem_rdata_in = mem_word(imem_addr_out);
  assign w_ready       = w_req;
  assign w_rdata       = mem_word(w_addr);

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush_in(flush_in),
    .redirect_in(redirect_in), .redirect_pc_in(redirect_pc_in),
    .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
    .imem_ready_in(imem_ready_in), .imem_rdata_in(imem_rdata_in),
    .instr_out(instr_out), .pc_out(pc_out), .pc_plus4_out(pc_plus4_out),
    .valid_out(valid_out)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .stall_in(tie0), .flush_in(tie0),
    .redirect_in(tie0), .redirect_pc_in(tie0_32),
    .imem_req_out(w_req), .imem_addr_out(w_addr),
    .imem_ready_in(w_ready), .imem_rdata_in(w_rdata),
    .instr_out(w_instr), .pc_out(w_pc), .pc_plus4_out(w_pc4),
    .valid_out(w_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what the bus and IF/ID must look like after each edge
  logic [31:0] m_pc;        // address being / to be fetched
  logic        m_req;       // request visible on the bus
  logic        m_buffered;  // a fetched word waits for the stall to clear
  logic [31:0] m_buf;
  logic        m_doomed;    // in-flight response must be thrown away
  logic [31:0] m_tgt;       // where to go once the doomed response lands
  logic [31:0] e_instr, e_pc, e_pc4;
  logic        e_valid;

  task automatic model_reset(input logic [31:0] rpc);
    m_pc = rpc; m_req = 1'b0; m_buffered = 1'b0; m_buf = '0;
    m_doomed = 1'b0; m_tgt = '0;
    e_instr = NOP; e_pc = '0; e_pc4 = '0; e_valid = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic fl, input logic rd,
                            input logic [31:0] rpc, input logic rdy);
    logic        got;
    logic        cap;
    logic [31:0] cw, cpc, t;
    got = m_req & rdy;
    cap = 1'b0; cw = '0; cpc = m_pc;
    t = {rpc[31:2], 2'b00};
    if (m_buffered) begin
      if (rd) begin
        m_buffered = 1'b0; m_pc = t;
      end else if (!st) begin
        cap = 1'b1; cw = m_buf; m_pc = m_pc + 32'd4; m_buffered = 1'b0;
      end
    end else if (m_doomed) begin
      if (got) begin
        m_pc = rd ? t : m_tgt; m_doomed = 1'b0;
      end else if (rd) begin
        m_tgt = t;
      end
    end else if (!m_req) begin
      if (rd) m_pc = t;
    end else if (got) begin
      if (rd) m_pc = t;
      else if (!st) begin cap = 1'b1; cw = mem_word(m_pc); m_pc = m_pc + 32'd4; end
      else begin m_buffered = 1'b1; m_buf = mem_word(m_pc); end
    end else if (rd) begin
      m_doomed = 1'b1; m_tgt = t;
    end
    m_req = !m_buffered;
    if (fl) begin
      e_valid = 1'b0; e_instr = NOP;
    end else if (!st) begin
      if (cap) begin
        e_valid = 1'b1; e_instr = cw; e_pc = cpc; e_pc4 = cpc + 32'd4;
      end else begin
        e_valid = 1'b0; e_instr = NOP;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle the model is live, the DUT must agree with it
  always @(posedge clk) begin
    #1;
    if (chk_en && rst_n) begin
      chk("req", 32'(imem_req_out), 32'(m_req));
      if (m_req) chk("addr", imem_addr_out, m_pc);
      chk("valid", 32'(valid_out), 32'(e_valid));
      chk("instr", instr_out, e_instr);
      if (e_valid) begin
        chk("pc_out", pc_out, e_pc);
        chk("pc4", pc_plus4_out, e_pc4);
      end
    end
  end

  // Called at a negedge; returns at the next negedge
  task automatic cyc(input logic st, input logic fl, input logic rd,
                     input logic [31:0] rpc, input logic rdy);
    stall_in = st; flush_in = fl; redirect_in = rd; redirect_pc_in = rpc; rdy_en = rdy;
    @(posedge clk);
    model_step(st, fl, rd, rpc, rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; chk_en = 1'b0;
    stall_in = 0; flush_in = 0; redirect_in = 0; redirect_pc_in = '0; rdy_en = 0;
    repeat (2) @(negedge clk);
    model_reset(32'h0);
    rst_n = 1'b1; chk_en = 1'b1;
  endtask

  initial begin
    tie0 = 1'b0; tie0_32 = '0;
    @(negedge clk);
    do_reset();

    // Reset values and zero-latency streaming
    chk("rst_req", 32'(imem_req_out), 32'h0);
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_instr", instr_out, NOP);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_pc4", pc_plus4_out, 32'h0);
    cyc(0, 0, 0, 0, 1);
    chk("A_req", 32'(imem_req_out), 32'h1);
    chk("A_addr", imem_addr_out, 32'h0);
    chk("W_addr0", w_addr, 32'hFFFF_FFF8);
    cyc(0, 0, 0, 0, 1);
    chk("A_i0", instr_out, 32'hFFF3_0293);
    chk("A_pc0", pc_out, 32'h0);
    chk("A_pc4_0", pc_plus4_out, 32'h4);
    chk("W_addr1", w_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 1);
    chk("A_i1", instr_out, 32'hFE20_AE23);
    chk("A_pc1", pc_out, 32'h4);
    chk("A_v1", 32'(valid_out), 32'h1);
    chk("W_addr2", w_addr, 32'h0000_0000);
    chk("W_pc", w_pc, 32'hFFFF_FFFC);
    chk("W_pc4", w_pc4, 32'h0000_0000);

    // Stall with ready at PC 0x8: held in skid buffer, no refetch
    cyc(1, 0, 0, 0, 1);
    chk("S_req", 32'(imem_req_out), 32'h0);
    chk("S_hold_pc", pc_out, 32'h4);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    chk("S_req3", 32'(imem_req_out), 32'h0);
    cyc(0, 0, 0, 0, 1);
    chk("S_i2", instr_out, 32'hFE00_8CE3);
    chk("S_pc2", pc_out, 32'h8);
    chk("S_pc4_2", pc_plus4_out, 32'hC);
    chk("S_addr", imem_addr_out, 32'hC);

    // Taken branch at 0xC with ready
    cyc(0, 1, 1, 32'h0000_0100, 1);
    chk("B_valid", 32'(valid_out), 32'h0);
    chk("B_instr", instr_out, NOP);
    chk("B_addr", imem_addr_out, 32'h100);
    cyc(0, 0, 0, 0, 1);
    chk("B_pc", pc_out, 32'h100);

    // Redirect while 0x10 pending; second redirect wins
    do_reset();
    repeat (5) cyc(0, 0, 0, 0, 1);
    chk("D_addr0", imem_addr_out, 32'h10);
    cyc(0, 0, 1, 32'h0000_0200, 0);
    chk("D_addr1", imem_addr_out, 32'h10);
    chk("D_req1", 32'(imem_req_out), 32'h1);
    cyc(0, 0, 1, 32'h0000_0301, 0);
    chk("D_addr2", imem_addr_out, 32'h10);
    cyc(0, 0, 0, 0, 1);
    chk("D_addr3", imem_addr_out, 32'h300);
    chk("D_valid", 32'(valid_out), 32'h0);

    // Async reset between edges while discarding
    do_reset();
    repeat (2) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 32'h0000_0040, 0);
    #3;
    rst_n = 1'b0; chk_en = 1'b0;
    #1;
    chk("R_req", 32'(imem_req_out), 32'h0);
    chk("R_valid", 32'(valid_out), 32'h0);
    chk("R_instr", instr_out, NOP);
    chk("R_pc", pc_out, 32'h0);
    @(negedge clk);
    do_reset();
    cyc(0, 0, 0, 0, 1);
    chk("R_addr", imem_addr_out, 32'h0);
    chk("R_req1", 32'(imem_req_out), 32'h1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 4) == 0, ($urandom % 8) == 0, ($urandom % 7) == 0,
          $urandom, ($urandom % 3) != 0);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
